// File: rtl/pll_mon_pkg.sv
// Shared definitions for the PLL clock monitor: FSM state encoding and default sizing.
package pll_mon_pkg;

    localparam int DEF_WINDOW       = 256;
    localparam int DEF_CNT_W        = 12;
    localparam int DEF_LOCK_WINDOWS = 4;

    // Lock streak never exceeds 15 windows
    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        EVAL    = 2'd2
    } state_e;

endpackage

// File: rtl/pll_mon_edge_sync.sv
// Three-flop synchroniser for the PLL-derived toggle; strobe marks either edge.
module pll_mon_edge_sync (
    input  logic ext_clk,
    input  logic resetb,
    input  logic tgl_i,
    output logic strobe_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge ext_clk or negedge resetb) begin
        if (!resetb) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= tgl_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // s1 may be metastable; only settled stages feed the edge detector
    assign strobe_o = s2_q ^ s3_q;

endmodule

// File: rtl/pll_clock_monitor.sv
// PLL frequency monitor in the ext_clk domain: counts synchronised pll_tgl edges per
// window, checks the count against cnt_min/cnt_max, and tracks lock and sticky failure.
module pll_clock_monitor
    import pll_mon_pkg::*;
#(
    parameter int WINDOW       = DEF_WINDOW,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
    input  logic             ext_clk,
    input  logic             resetb,
    input  logic             enable,
    input  logic             pll_tgl,
    input  logic [CNT_W-1:0] cnt_min,
    input  logic [CNT_W-1:0] cnt_max,
    input  logic             fail_clr,
    output logic             pll_ok,
    output logic             pll_fail,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_done
);

    localparam int                  WIN_W    = $clog2(WINDOW);
    localparam logic [WIN_W-1:0]    WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [STREAK_W-1:0] LOCK_N   = STREAK_W'(LOCK_WINDOWS);

    logic                strobe;
    state_e              state_q;
    logic [WIN_W-1:0]    win_q;
    logic [CNT_W-1:0]    edge_q, edge_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                pll_ok_q, pll_fail_q, meas_done_q;
    logic [CNT_W-1:0]    meas_count_q;
    logic                good, fail_set;

    pll_mon_edge_sync u_sync (
        .ext_clk  (ext_clk),
        .resetb   (resetb),
        .tgl_i    (pll_tgl),
        .strobe_o (strobe)
    );

    assign edge_d   = (strobe && (edge_q != '1)) ? edge_q + 1'b1 : edge_q;
    assign good     = (cnt_min <= edge_q) && (edge_q <= cnt_max);
    assign streak_d = !good              ? '0 :
                      (streak_q == LOCK_N) ? streak_q : streak_q + 1'b1;
    assign fail_set = (state_q == EVAL) && !good && pll_ok_q;

    always_ff @(posedge ext_clk or negedge resetb) begin
        if (!resetb) begin
            state_q      <= IDLE;
            win_q        <= '0;
            edge_q       <= '0;
            streak_q     <= '0;
            pll_ok_q     <= 1'b0;
            pll_fail_q   <= 1'b0;
            meas_count_q <= '0;
            meas_done_q  <= 1'b0;
        end else begin
            meas_done_q <= 1'b0;
            if (fail_clr)
                pll_fail_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    win_q    <= '0;
                    edge_q   <= '0;
                    streak_q <= '0;
                    pll_ok_q <= 1'b0;
                    if (enable)
                        state_q <= MEASURE;
                end
                MEASURE: begin
                    if (!enable) begin
                        state_q  <= IDLE;
                        win_q    <= '0;
                        edge_q   <= '0;
                        streak_q <= '0;
                        pll_ok_q <= 1'b0;
                    end else begin
                        edge_q <= edge_d;
                        win_q  <= win_q + 1'b1;
                        // Publish the final count on EVAL entry so it is valid with meas_done
                        if (win_q == WIN_LAST) begin
                            state_q      <= EVAL;
                            meas_count_q <= edge_d;
                            meas_done_q  <= 1'b1;
                        end
                    end
                end
                EVAL: begin
                    streak_q <= streak_d;
                    pll_ok_q <= good && (streak_d == LOCK_N);
                    if (fail_set)
                        pll_fail_q <= 1'b1;
                    // An edge arriving now belongs to the next window
                    edge_q  <= CNT_W'(strobe);
                    win_q   <= '0;
                    state_q <= enable ? MEASURE : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pll_ok     = pll_ok_q;
    assign pll_fail   = pll_fail_q;
    assign meas_count = meas_count_q;
    assign meas_done  = meas_done_q;

endmodule

// File: tb/tb_pll_clock_monitor.sv
// Bench for pll_clock_monitor: window-level reference model fed by the recorded toggle history.
module tb_pll_clock_monitor;

    localparam int WIN = 256;
    localparam int PER = WIN + 1;

    logic        ext_clk = 1'b0, resetb = 1'b0, enable = 1'b0, pll_tgl = 1'b0, fail_clr = 1'b0;
    logic [11:0] cnt_min = 12'd60, cnt_max = 12'd68;
    logic        pll_ok, pll_fail, meas_done;
    logic [11:0] meas_count;
    logic        en_s = 1'b0, tgl_s = 1'b0;
    logic        pll_ok_s, pll_fail_s, meas_done_s;
    logic [7:0]  meas_count_s;

    always #5 ext_clk = ~ext_clk;

    pll_clock_monitor #(.WINDOW(WIN), .CNT_W(12), .LOCK_WINDOWS(4)) u_dut (
        .ext_clk(ext_clk), .resetb(resetb), .enable(enable), .pll_tgl(pll_tgl),
        .cnt_min(cnt_min), .cnt_max(cnt_max), .fail_clr(fail_clr),
        .pll_ok(pll_ok), .pll_fail(pll_fail), .meas_count(meas_count), .meas_done(meas_done)
    );

    pll_clock_monitor #(.WINDOW(WIN), .CNT_W(8), .LOCK_WINDOWS(4)) u_sat (
        .ext_clk(ext_clk), .resetb(resetb), .enable(en_s), .pll_tgl(tgl_s),
        .cnt_min(8'd60), .cnt_max(8'd68), .fail_clr(1'b0),
        .pll_ok(pll_ok_s), .pll_fail(pll_fail_s), .meas_count(meas_count_s), .meas_done(meas_done_s)
    );

    typedef struct {
        int per;
        int lo;
        int hi;
        bit ok;
        bit fail;
        bit clr;
    } vec_t;

    vec_t tbl [0:10];

    int checks = 0, passed = 0;
    int cyc = 10;
    bit hist [0:65535];
    int cur_per = 0, tgl_at = -1;
    bit sat_run = 1'b0;
    int base = 0, k = 0, m_streak = 0, m_cnt = 0;
    bit m_ok = 1'b0, m_fail = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // One ext_clk edge: record the toggle level seen at the edge, then drive the next level
    task automatic tick();
        @(posedge ext_clk);
        cyc++;
        hist[cyc] = pll_tgl;
        #1;
        if (cur_per > 0 && (cyc % cur_per) == 0) pll_tgl = ~pll_tgl;
        if (cyc == tgl_at) pll_tgl = ~pll_tgl;
        if (sat_run) tgl_s = ~tgl_s;
    endtask

    // A level change first seen at edge j is counted by the edge j+2
    function automatic int strobes(input int a, input int b);
        int n = 0;
        for (int m = a; m <= b; m++) n += int'(hist[m-2] ^ hist[m-3]);
        return n;
    endfunction

    task automatic do_reset();
        enable = 1'b0; en_s = 1'b0; sat_run = 1'b0; cur_per = 0; tgl_at = -1;
        pll_tgl = 1'b0; tgl_s = 1'b0; fail_clr = 1'b0;
        resetb = 1'b0;
        #1;
        chk("rst_ok", pll_ok, 0);
        chk("rst_fail", pll_fail, 0);
        chk("rst_count", meas_count, 0);
        chk("rst_done", meas_done, 0);
        repeat (4) tick();
        resetb = 1'b1; enable = 1'b1;
        base = cyc + 1; k = 0; m_streak = 0; m_ok = 1'b0; m_fail = 1'b0;
    endtask

    task automatic run_window(input int per, input bit clr, output int cnt);
        int  done, lo;
        bit  good, set;
        done = base + PER * k + WIN;
        lo   = (k == 0) ? base + 1 : base + PER * k;
        cur_per = per;
        while (cyc < done - 1) tick();
        chk("done_early", meas_done, 0);
        tick();
        chk("meas_done", meas_done, 1);
        m_cnt = strobes(lo, done);
        chk("meas_count", meas_count, m_cnt);
        if (sat_run && k >= 1) begin
            chk("sat_done", meas_done_s, 1);
            chk("sat_count", meas_count_s, 255);
        end
        fail_clr = clr;
        tick();
        fail_clr = 1'b0;
        good     = (m_cnt >= int'(cnt_min)) && (m_cnt <= int'(cnt_max));
        set      = !good && m_ok;
        m_streak = good ? ((m_streak < 4) ? m_streak + 1 : 4) : 0;
        m_ok     = (m_streak == 4);
        m_fail   = set ? 1'b1 : (clr ? 1'b0 : m_fail);
        chk("pll_ok", pll_ok, m_ok);
        chk("pll_fail", pll_fail, m_fail);
        if (sat_run && k >= 1) begin
            chk("sat_ok", pll_ok_s, 0);
            chk("sat_fail", pll_fail_s, 0);
        end
        k++;
        cnt = m_cnt;
    endtask

    initial begin
        int c, c2, c3, per;
        bit saw, clr;
        tbl[0]  = '{4, 64, 64, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4, 62, 66, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4, 62, 66, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4, 62, 66, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{8, 31, 34, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{4, 62, 66, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{4, 62, 66, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{4, 62, 66, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{4, 62, 66, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{4, 62, 66, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{8, 31, 34, 1'b0, 1'b1, 1'b1};

        // Lock, frequency fault, sticky fail, clear in EVAL, set-beats-clear
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            run_window(tbl[i].per, tbl[i].clr, c);
            chk($sformatf("tbl%0d_band", i), (meas_count >= 12'(tbl[i].lo)) && (meas_count <= 12'(tbl[i].hi)), 1);
            chk($sformatf("tbl%0d_ok", i), pll_ok, tbl[i].ok);
            chk($sformatf("tbl%0d_fail", i), pll_fail, tbl[i].fail);
        end

        // Reset in the middle of a window clears the sticky fail at once
        cur_per = 4;
        while (cyc < base + PER * k + 50) tick();
        do_reset();

        // Relock, then drop enable mid-window
        for (int i = 0; i <= 3; i++) begin
            run_window(4, 1'b0, c);
            chk($sformatf("relock%0d_ok", i), pll_ok, tbl[i].ok);
        end
        while (cyc < base + PER * k + 100) tick();
        enable = 1'b0;
        tick();
        chk("drop_ok", pll_ok, 0);
        chk("drop_fail", pll_fail, m_fail);
        chk("drop_count", meas_count, m_cnt);
        chk("drop_done", meas_done, 0);
        saw = 1'b0;
        repeat (300) begin
            tick();
            if (meas_done) saw = 1'b1;
        end
        chk("idle_no_done", saw, 0);
        chk("idle_count_hold", meas_count, m_cnt);
        enable = 1'b1;
        base = cyc + 1; k = 0; m_streak = 0; m_ok = 1'b0;
        run_window(4, 1'b0, c);
        chk("reenable_count", meas_count, 64);

        // Dead PLL, saturating sibling, and one edge landing in the EVAL cycle
        do_reset();
        en_s = 1'b1; sat_run = 1'b1;
        run_window(0, 1'b0, c);
        chk("hold0_count", meas_count, 0);
        run_window(0, 1'b0, c);
        chk("hold1_count", meas_count, 0);
        tgl_at = base + PER * 2 + WIN - 2;
        run_window(0, 1'b0, c2);
        chk("eval_edge_this", meas_count, 0);
        run_window(0, 1'b0, c3);
        chk("eval_edge_next", meas_count, 1);
        chk("hold_ok", pll_ok, 0);
        chk("hold_fail", pll_fail, 0);

        // Randomised windows against the model, including inverted thresholds
        do_reset();
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 5))
                0: per = 0;
                1: per = 3;
                2: per = 5;
                3: per = 8;
                default: per = 4;
            endcase
            if (i == 5) begin
                cnt_min = 12'd70; cnt_max = 12'd50;
            end else if ($urandom_range(0, 9) < 7) begin
                cnt_min = 12'd60; cnt_max = 12'd68;
            end else begin
                cnt_min = 12'($urandom_range(20, 70));
                cnt_max = cnt_min + 12'($urandom_range(0, 40)) - 12'd5;
            end
            clr = ($urandom_range(0, 3) == 0);
            run_window(per, clr, c);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
